purify_ctrl: RTL and testbench

Frame/line sequencer for the 3x3 purify filter in the camera pipeline. Sits between the sensor capture stage (iFVAL/iDVAL) and the purify datapath. It gates the line-buffer clock enable, tracks pixel coordinates, and flags which accepted pixels carry a complete 3x3 window. It also reports frame completion and malformed frames, so downstream logic can zero incomplete windows and count frames.

---
 rtl/purify_pkg.sv | 19 +
 rtl/purify_pix_cnt.sv | 42 ++++
 rtl/purify_ctrl.sv | 130 +++++++++++++
 tb/tb_purify_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/purify_pkg.sv
// Shared definitions for the 3x3 purify filter: sequencer states, default
// frame geometry and counter widths, and the window size used by the filter
// and line buffer.
package purify_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned H_ACTIVE_DEF = 800;
  localparam int unsigned V_ACTIVE_DEF = 600;
  localparam int unsigned XW_DEF       = 12;
  localparam int unsigned YW_DEF       = 12;
  localparam int unsigned WIN_SIZE     = 3;

endpackage

// File: rtl/purify_pix_cnt.sv
// Pixel coordinate counter for the purify sequencer.
//   iCLK, iRST_N : clock, asynchronous active-low reset
//   clr          : synchronous clear of x and y (held while idle)
//   inc          : advance one pixel; x wraps at H_ACTIVE-1 and bumps y
//   x, y         : current column / row of the next pixel to be accepted
//   line_wrap    : combinational strobe, the current increment ends a line
module purify_pix_cnt #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned XW       = 12,
  parameter int unsigned YW       = 12
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          clr,
  input  logic          inc,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_wrap
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);

  assign line_wrap = inc & (x == X_LAST);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/purify_ctrl.sv
// Frame/line sequencer for the 3x3 purify filter.
//   iCLK, iRST_N : pixel clock, asynchronous active-low reset
//   iFVAL, iDVAL : frame / pixel valid from capture
//   iEN          : filter enable, only looked at while idle
//   oCLKen       : line-buffer shift enable (combinational accept)
//   oPIX_VAL     : a pixel was accepted last cycle
//   oWIN_VAL     : that pixel completed a full 3x3 window
//   oX, oY       : window-centre coordinate of that pixel (x-1, y-1)
//   oFRAME_DONE  : one-cycle pulse, frame completed with V_ACTIVE lines
//   oERR         : one-cycle pulse, short frame or surplus pixel
module purify_ctrl
  import purify_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned XW       = XW_DEF,
  parameter int unsigned YW       = YW_DEF
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iFVAL,
  input  logic          iDVAL,
  input  logic          iEN,
  output logic          oCLKen,
  output logic          oPIX_VAL,
  output logic          oWIN_VAL,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY,
  output logic          oFRAME_DONE,
  output logic          oERR
);

  localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [XW-1:0] X_WIN  = XW'(WIN_SIZE - 1);
  localparam logic [YW-1:0] Y_WIN  = YW'(WIN_SIZE - 1);

  state_t        state, state_nxt;
  logic          fval_q;
  logic          armed;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_wrap;
  logic          active, y_full, accept, extra;
  logic          fval_rise, fval_fall, frame_ok, err_nxt;

  assign active    = (state == FILL) || (state == RUN);
  assign y_full    = (y == Y_END);
  assign accept    = iDVAL & active & ~y_full;
  assign extra     = iDVAL & active & y_full;
  assign oCLKen    = accept;

  // A frame left high across reset must not look like a new start: the
  // rising edge only counts once iFVAL has been seen low since reset.
  assign fval_rise = iFVAL & ~fval_q & armed;
  assign fval_fall = ~iFVAL & fval_q;

  // A pixel accepted in the fall cycle is counted first, so the last line
  // may complete in that same cycle.
  assign frame_ok  = y_full | (line_wrap & (y == Y_LAST));

  purify_pix_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_pix_cnt (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .clr       (state == IDLE),
    .inc       (accept),
    .x         (x),
    .y         (y),
    .line_wrap (line_wrap)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state  <= IDLE;
      fval_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      state  <= state_nxt;
      fval_q <= iFVAL;
      if (!iFVAL) armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = extra;
    unique case (state)
      IDLE: if (fval_rise && iEN) state_nxt = FILL;
      FILL, RUN: begin
        if (fval_fall) begin
          if (frame_ok) begin
            state_nxt = DONE;
          end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end else if (state == FILL && line_wrap && y == YW'(1)) begin
          state_nxt = RUN;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oPIX_VAL    <= 1'b0;
      oWIN_VAL    <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oFRAME_DONE <= 1'b0;
      oERR        <= 1'b0;
    end else begin
      oPIX_VAL    <= accept;
      oWIN_VAL    <= accept && (x >= X_WIN) && (y >= Y_WIN);
      oFRAME_DONE <= (state == DONE);
      oERR        <= err_nxt;
      if (accept) begin
        oX <= x - 1'b1;
        oY <= y - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_purify_ctrl.sv
// Directed bench for purify_ctrl with an 8x6 frame geometry.
module tb_purify_ctrl;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int XW = 4;
  localparam int YW = 4;

  logic          iCLK = 1'b0;
  logic          iRST_N, iFVAL, iDVAL, iEN;
  logic          oCLKen, oPIX_VAL, oWIN_VAL, oFRAME_DONE, oERR;
  logic [XW-1:0] oX;
  logic [YW-1:0] oY;

  always #5 iCLK = ~iCLK;

  purify_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW)) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iFVAL       (iFVAL),
    .iDVAL       (iDVAL),
    .iEN         (iEN),
    .oCLKen      (oCLKen),
    .oPIX_VAL    (oPIX_VAL),
    .oWIN_VAL    (oWIN_VAL),
    .oX          (oX),
    .oY          (oY),
    .oFRAME_DONE (oFRAME_DONE),
    .oERR        (oERR)
  );

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int fall_cyc, done_cyc;
  int n_clken, n_pix, n_win, n_done, n_err, hold_bad;
  logic [XW-1:0] first_wx, last_wx, first_px, prev_x;
  logic [YW-1:0] first_wy, last_wy, first_py, prev_y;

  // Output monitor, sampled mid-cycle.
  always @(negedge iCLK) begin
    if (oCLKen) n_clken++;
    if (oPIX_VAL) begin
      if (n_pix == 0) begin first_px = oX; first_py = oY; end
      n_pix++;
    end else if (oX !== prev_x || oY !== prev_y) begin
      hold_bad++;
    end
    if (oWIN_VAL) begin
      if (n_win == 0) begin first_wx = oX; first_wy = oY; end
      last_wx = oX;
      last_wy = oY;
      n_win++;
    end
    if (oFRAME_DONE) begin n_done++; done_cyc = cyc; end
    if (oERR) n_err++;
    prev_x = oX;
    prev_y = oY;
    cyc++;
  end

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic clear_mon;
    n_clken = 0; n_pix = 0; n_win = 0; n_done = 0; n_err = 0; hold_bad = 0;
    done_cyc = -1; fall_cyc = -100;
    first_wx = '0; first_wy = '0; last_wx = '0; last_wy = '0;
    first_px = '0; first_py = '0;
  endtask

  task automatic send_frame(input int npix, input int gap, input bit fall_with_last);
    iFVAL = 1'b1;
    tick; tick;
    for (int i = 0; i < npix; i++) begin
      iDVAL = 1'b1;
      if (fall_with_last && i == npix - 1) begin
        iFVAL    = 1'b0;
        fall_cyc = cyc;
      end
      tick;
      iDVAL = 1'b0;
      for (int g = 0; g < gap; g++) tick;
    end
    if (!fall_with_last) begin
      iFVAL    = 1'b0;
      fall_cyc = cyc;
      tick;
    end
    repeat (4) tick;
  endtask

  task automatic test_reset;
    iRST_N = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0; iEN = 1'b1;
    @(negedge iCLK);
    checks++;
    if ({oCLKen, oPIX_VAL, oWIN_VAL, oX, oY, oFRAME_DONE, oERR} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0",
               {oCLKen, oPIX_VAL, oWIN_VAL, oX, oY, oFRAME_DONE, oERR});
    end
    tick; tick;
    iRST_N = 1'b1;
    tick; tick;
  endtask

  task automatic test_clean_frame;
    clear_mon;
    iEN = 1'b1;
    send_frame(48, 0, 1'b1);
    checks++; if (n_clken !== 48) begin errors++; $display("FAIL clean_clken got=%0d exp=48", n_clken); end
    checks++; if (n_pix !== 48) begin errors++; $display("FAIL clean_pixval got=%0d exp=48", n_pix); end
    checks++; if (n_win !== 24) begin errors++; $display("FAIL clean_winval got=%0d exp=24", n_win); end
    checks++; if (first_wx !== 4'd1 || first_wy !== 4'd1) begin errors++; $display("FAIL clean_first_win got=(%0d,%0d) exp=(1,1)", first_wx, first_wy); end
    checks++; if (last_wx !== 4'd6 || last_wy !== 4'd4) begin errors++; $display("FAIL clean_last_win got=(%0d,%0d) exp=(6,4)", last_wx, last_wy); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL clean_done_count got=%0d exp=1", n_done); end
    checks++; if (done_cyc - fall_cyc !== 2) begin errors++; $display("FAIL clean_done_latency got=%0d exp=2", done_cyc - fall_cyc); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL clean_err got=%0d exp=0", n_err); end
  endtask

  task automatic test_bypass;
    clear_mon;
    iEN = 1'b0;
    iFVAL = 1'b1;
    tick; tick;
    for (int i = 0; i < 48; i++) begin
      iDVAL = 1'b1;
      if (i == 10) iEN = 1'b1;
      tick;
    end
    iDVAL = 1'b0;
    iFVAL = 1'b0;
    repeat (5) tick;
    checks++; if (n_clken !== 0) begin errors++; $display("FAIL bypass_clken got=%0d exp=0", n_clken); end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL bypass_done got=%0d exp=0", n_done); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL bypass_err got=%0d exp=0", n_err); end
    clear_mon;
    send_frame(48, 0, 1'b0);
    checks++; if (n_clken !== 48) begin errors++; $display("FAIL bypass_next_clken got=%0d exp=48", n_clken); end
    checks++; if (n_win !== 24) begin errors++; $display("FAIL bypass_next_win got=%0d exp=24", n_win); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL bypass_next_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_short_frame;
    clear_mon;
    iEN = 1'b1;
    send_frame(24, 0, 1'b0);
    checks++; if (n_clken !== 24) begin errors++; $display("FAIL short_clken got=%0d exp=24", n_clken); end
    checks++; if (n_err !== 1) begin errors++; $display("FAIL short_err got=%0d exp=1", n_err); end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL short_done got=%0d exp=0", n_done); end
    clear_mon;
    send_frame(48, 0, 1'b0);
    checks++; if (first_px !== 4'hF || first_py !== 4'hF) begin errors++; $display("FAIL short_next_origin got=(%0d,%0d) exp=(15,15)", first_px, first_py); end
    checks++; if (first_wx !== 4'd1 || first_wy !== 4'd1) begin errors++; $display("FAIL short_next_first_win got=(%0d,%0d) exp=(1,1)", first_wx, first_wy); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL short_next_done got=%0d exp=1", n_done); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL short_next_err got=%0d exp=0", n_err); end
  endtask

  task automatic test_extra_pixels;
    clear_mon;
    send_frame(50, 0, 1'b0);
    checks++; if (n_clken !== 48) begin errors++; $display("FAIL extra_clken got=%0d exp=48", n_clken); end
    checks++; if (n_pix !== 48) begin errors++; $display("FAIL extra_pixval got=%0d exp=48", n_pix); end
    checks++; if (n_err !== 2) begin errors++; $display("FAIL extra_err got=%0d exp=2", n_err); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL extra_done got=%0d exp=1", n_done); end
    checks++; if (done_cyc - fall_cyc !== 2) begin errors++; $display("FAIL extra_done_latency got=%0d exp=2", done_cyc - fall_cyc); end
  endtask

  task automatic test_reset_mid_frame;
    clear_mon;
    iFVAL = 1'b1;
    tick; tick;
    for (int i = 0; i < 20; i++) begin
      iDVAL = 1'b1;
      tick;
    end
    iRST_N = 1'b0;
    @(negedge iCLK);
    checks++;
    if ({oCLKen, oPIX_VAL, oWIN_VAL, oX, oY, oFRAME_DONE, oERR} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got=%b exp=0",
               {oCLKen, oPIX_VAL, oWIN_VAL, oX, oY, oFRAME_DONE, oERR});
    end
    tick; tick;
    iRST_N = 1'b1;
    clear_mon;
    repeat (10) tick;
    checks++; if (n_clken !== 0) begin errors++; $display("FAIL midreset_no_restart got=%0d exp=0", n_clken); end
    iDVAL = 1'b0;
    iFVAL = 1'b0;
    tick; tick;
    clear_mon;
    send_frame(48, 0, 1'b0);
    checks++; if (n_clken !== 48) begin errors++; $display("FAIL midreset_next_clken got=%0d exp=48", n_clken); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL midreset_next_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_gapped;
    clear_mon;
    send_frame(48, 2, 1'b0);
    checks++; if (n_clken !== 48) begin errors++; $display("FAIL gap_clken got=%0d exp=48", n_clken); end
    checks++; if (n_win !== 24) begin errors++; $display("FAIL gap_winval got=%0d exp=24", n_win); end
    checks++; if (first_wx !== 4'd1 || first_wy !== 4'd1) begin errors++; $display("FAIL gap_first_win got=(%0d,%0d) exp=(1,1)", first_wx, first_wy); end
    checks++; if (last_wx !== 4'd6 || last_wy !== 4'd4) begin errors++; $display("FAIL gap_last_win got=(%0d,%0d) exp=(6,4)", last_wx, last_wy); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL gap_hold got=%0d exp=0", hold_bad); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL gap_done got=%0d exp=1", n_done); end
  endtask

  initial begin
    clear_mon;
    test_reset;
    test_clean_frame;
    test_bypass;
    test_short_frame;
    test_extra_pixels;
    test_reset_mid_frame;
    test_gapped;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
